// File: rtl/i2c_bit_sequencer_pkg.sv
// Shared encodings for the I2C master bit sequencer: command ops, FSM states, ACK slot index.
package i2c_bit_sequencer_pkg;

  localparam int unsigned ST_W  = 3;
  localparam int unsigned Q_W   = 2;
  localparam int unsigned IDX_W = 4;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_BYTE  = 2'b10;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_RSTART = 3'd1;
  localparam logic [ST_W-1:0] ST_START  = 3'd2;
  localparam logic [ST_W-1:0] ST_HOLD   = 3'd3;
  localparam logic [ST_W-1:0] ST_BYTE   = 3'd4;
  localparam logic [ST_W-1:0] ST_STOP   = 3'd5;

  localparam logic [IDX_W-1:0] BIT_ACK = 4'd8;

  // States in which a new command may be accepted
  function automatic logic is_quiet(input logic [ST_W-1:0] s);
    return (s == ST_IDLE) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-period timer: counts 0..prescale, ticks on the terminal count, then restarts.
module i2c_quarter_timer #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  hold,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  // A held timer never ticks, even with prescale=0
  assign tick = !hold && (count == prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear || hold || tick) begin
      count <= '0;
    end else begin
      count <= count + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/i2c_bit_sequencer.sv
// I2C master bus-phase sequencer: START/repeated START/STOP and 9-bit byte frames on quarter ticks.
// Optional SCL clock stretching (scl_in port) when I2C_CLK_STRETCH_EN is defined.
module i2c_bit_sequencer
  import i2c_bit_sequencer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  asyn_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [PRESCALE_W-1:0] prescale,
`ifdef I2C_CLK_STRETCH_EN
  input  logic                  scl_in,
`endif
  output logic                  scl_out,
  output logic                  sda_force_en,
  output logic                  sda_force_val,
  output logic                  shift_stb,
  output logic                  sample_stb,
  output logic [IDX_W-1:0]      bit_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  logic [ST_W-1:0]       state, state_n;
  logic [Q_W-1:0]        q, q_n;
  logic [IDX_W-1:0]      idx_n;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  accept, tick, hold;
  logic                  scl_n, en_n, val_n, shift_n, sample_n, done_n, err_n;

  assign accept = cmd_valid && cmd_ready;

`ifdef I2C_CLK_STRETCH_EN
  // Rising-SCL quarters wait for the bus to actually release SCL
  assign hold = !scl_in && (((state == ST_BYTE) && (q == 2'd2)) ||
                            ((state == ST_STOP) && (q == 2'd1)));
`else
  assign hold = 1'b0;
`endif

  i2c_quarter_timer #(.PRESCALE_W(PRESCALE_W)) u_timer (
    .clk      (clk),
    .rst      (asyn_rst),
    .clear    (is_quiet(state)),
    .hold     (hold),
    .prescale (prescale_q),
    .tick     (tick)
  );

  always_comb begin
    state_n  = state;
    q_n      = q;
    idx_n    = bit_idx;
    shift_n  = 1'b0;
    sample_n = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      ST_IDLE, ST_HOLD: begin
        q_n = '0;
        if (accept) begin
          case (cmd_op)
            OP_START: state_n = (state == ST_HOLD) ? ST_RSTART : ST_START;
            OP_STOP: begin
              if (state == ST_HOLD) state_n = ST_STOP;
              else done_n = 1'b1;
            end
            OP_BYTE: begin
              if (state == ST_HOLD) begin
                state_n = ST_BYTE;
                idx_n   = '0;
                shift_n = 1'b1;
              end else begin
                err_n = 1'b1;
              end
            end
            default: err_n = 1'b1;
          endcase
        end
      end
      ST_RSTART: if (tick) state_n = ST_START;
      ST_START: begin
        if (tick) begin
          if (q == 2'd1) begin
            state_n = ST_HOLD;
            done_n  = 1'b1;
          end else begin
            q_n = q + 2'd1;
          end
        end
      end
      ST_BYTE: begin
        if (tick) begin
          q_n = q + 2'd1;
          if (q == 2'd2) sample_n = 1'b1;
          if (q == 2'd3) begin
            if (bit_idx == BIT_ACK) begin
              state_n = ST_HOLD;
              idx_n   = '0;
              done_n  = 1'b1;
            end else begin
              idx_n   = bit_idx + 4'd1;
              shift_n = 1'b1;
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (q == 2'd2) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            q_n = q + 2'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Pad controls follow the phase being entered so they change with the state
    scl_n = 1'b1;
    en_n  = 1'b0;
    val_n = 1'b1;
    case (state_n)
      ST_RSTART: begin
        scl_n = 1'b0;
        en_n  = 1'b1;
      end
      ST_START: begin
        en_n  = 1'b1;
        val_n = (q_n == 2'd0);
      end
      ST_HOLD: scl_n = 1'b0;
      ST_BYTE: scl_n = q_n[1];
      ST_STOP: begin
        scl_n = (q_n != 2'd0);
        en_n  = 1'b1;
        val_n = (q_n == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (asyn_rst) begin
      state         <= ST_IDLE;
      q             <= '0;
      bit_idx       <= '0;
      prescale_q    <= '0;
      scl_out       <= 1'b1;
      sda_force_en  <= 1'b0;
      sda_force_val <= 1'b1;
      shift_stb     <= 1'b0;
      sample_stb    <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
      cmd_ready     <= 1'b1;
    end else begin
      state         <= state_n;
      q             <= q_n;
      bit_idx       <= idx_n;
      if (accept) prescale_q <= prescale;
      scl_out       <= scl_n;
      sda_force_en  <= en_n;
      sda_force_val <= val_n;
      shift_stb     <= shift_n;
      sample_stb    <= sample_n;
      done          <= done_n;
      err           <= err_n;
      busy          <= !is_quiet(state_n);
      cmd_ready     <= is_quiet(state_n);
    end
  end

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// Bench for i2c_bit_sequencer: per-cycle phase-table model plus literal latency checks.
module tb_i2c_bit_sequencer;
  import i2c_bit_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       asyn_rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] prescale = 8'd0;
  logic       scl_out, sda_force_en, sda_force_val, shift_stb, sample_stb;
  logic [3:0] bit_idx;
  logic       busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit owned   = 1'b0;
  logic [12:0] mq[$];

  always #5 clk = ~clk;

  i2c_bit_sequencer #(.PRESCALE_W(8)) dut (
    .clk           (clk),
    .asyn_rst      (asyn_rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .prescale      (prescale),
`ifdef I2C_CLK_STRETCH_EN
    .scl_in        (scl_out),
`endif
    .scl_out       (scl_out),
    .sda_force_en  (sda_force_en),
    .sda_force_val (sda_force_val),
    .shift_stb     (shift_stb),
    .sample_stb    (sample_stb),
    .bit_idx       (bit_idx),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  function automatic logic [12:0] vec(input logic scl, input logic en, input logic val,
                                      input logic sh, input logic sa, input logic [3:0] idx,
                                      input logic bsy, input logic dn, input logic er,
                                      input logic rdy);
    return {rdy, er, dn, bsy, idx, sa, sh, val, en, scl};
  endfunction

  // Bus idle (SCL/SDA released) or owned (SCL low), optionally with a done/err pulse
  function automatic logic [12:0] quiet(input bit own, input logic dn, input logic er);
    return own ? vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, dn, er, 1'b1)
               : vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, dn, er, 1'b1);
  endfunction

  task automatic push_n(input logic [12:0] v, input int n);
    for (int i = 0; i < n; i++) mq.push_back(v);
  endtask

  // Expected per-cycle outputs following an accepted command
  task automatic model_accept(input logic [1:0] op, input logic [7:0] pre);
    int p;
    p = int'(pre) + 1;
    case (op)
      OP_START: begin
        if (owned) push_n(vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), p);
        push_n(vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), p);
        push_n(vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), p);
        owned = 1'b1;
        mq.push_back(quiet(1'b1, 1'b1, 1'b0));
      end
      OP_STOP: begin
        if (owned) begin
          push_n(vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), p);
          push_n(vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), p);
          push_n(vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), p);
        end
        owned = 1'b0;
        mq.push_back(quiet(1'b0, 1'b1, 1'b0));
      end
      OP_BYTE: begin
        if (owned) begin
          for (int b = 0; b < 9; b++)
            for (int qq = 0; qq < 4; qq++)
              for (int c = 0; c < p; c++)
                mq.push_back(vec(logic'(qq >= 2), 1'b0, 1'b1, logic'(qq == 0 && c == 0),
                                 logic'(qq == 3 && c == 0), 4'(b), 1'b1, 1'b0, 1'b0, 1'b0));
          mq.push_back(quiet(1'b1, 1'b1, 1'b0));
        end else begin
          mq.push_back(quiet(1'b0, 1'b0, 1'b1));
        end
      end
      default: mq.push_back(quiet(owned, 1'b0, 1'b1));
    endcase
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [12:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = (mq.size() != 0) ? mq.pop_front() : quiet(owned, 1'b0, 1'b0);
      act_v = {cmd_ready, err, done, busy, bit_idx, sample_stb, shift_stb,
               sda_force_val, sda_force_en, scl_out};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle t=%0t rdy,err,done,busy,idx,sa,sh,val,en,scl got %b required %b",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  // Issue one command; optionally measure cycles to done/err and first SDA-low-forced cycle
  task automatic issue(input logic [1:0] op, input logic [7:0] pre, input bit wait_done,
                       input int exp_lat, input int exp_fall, input bit poke, input string name);
    int guard, lat, fall;
    guard = 0;
    @(posedge clk); #1;
    while (mq.size() != 0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) check({name, "_ready_timeout"}, guard, 0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    prescale  = pre;
    @(posedge clk);
    model_accept(op, pre);
    #1;
    cmd_valid = 1'b0;
    prescale  = 8'($urandom_range(0, 255));
    if (!wait_done) return;
    lat  = 0;
    fall = -1;
    while (1) begin
      if (fall < 0 && sda_force_en && !sda_force_val) fall = lat;
      if (done || err || lat >= 1000) break;
      if (poke && lat == 20) begin
        cmd_valid = 1'b1;
        cmd_op    = OP_STOP;
        prescale  = 8'd0;
      end
      if (poke && lat == 26) cmd_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_sda_fall"}, fall, exp_fall);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    asyn_rst = 1'b0;
    chk_en   = 1'b1;
    check("rst_scl", int'(scl_out), 1);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_sda_val", int'(sda_force_val), 1);

    issue(OP_BYTE, 8'd3, 1'b1, 0, -1, 1'b0, "byte_in_idle");
    issue(2'b11,   8'd3, 1'b1, 0, -1, 1'b0, "op11_idle");
    issue(OP_STOP, 8'd3, 1'b1, 0, -1, 1'b0, "stop_in_idle");
    issue(OP_START, 8'd3, 1'b1, 8, 4, 1'b0, "start_p3");
    issue(OP_BYTE,  8'd3, 1'b1, 144, -1, 1'b1, "byte_p3");
    issue(2'b11,    8'd3, 1'b1, 0, -1, 1'b0, "op11_hold");
    issue(OP_START, 8'd3, 1'b1, 12, 8, 1'b0, "rstart_p3");
    issue(OP_STOP,  8'd3, 1'b1, 12, 0, 1'b0, "stop_p3");
    issue(OP_START, 8'd0, 1'b1, 2, 1, 1'b0, "start_p0");
    issue(OP_BYTE,  8'd0, 1'b1, 36, -1, 1'b0, "byte_p0");
    issue(OP_STOP,  8'd0, 1'b1, 3, 0, 1'b0, "stop_p0");
    check("idle_scl_after_stop", int'(scl_out), 1);
    check("idle_val_after_stop", int'(sda_force_val), 1);

    // Reset in the middle of bit 4 of a byte
    issue(OP_START, 8'd3, 1'b1, 8, 4, 1'b0, "start_pre_rst");
    issue(OP_BYTE,  8'd3, 1'b0, 0, 0, 1'b0, "byte_pre_rst");
    repeat (70) @(posedge clk);
    #1;
    check("mid_byte_idx", int'(bit_idx), 4);
    asyn_rst = 1'b1;
    @(posedge clk);
    mq.delete();
    owned = 1'b0;
    #1;
    asyn_rst = 1'b0;
    check("post_rst_scl", int'(scl_out), 1);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_idx", int'(bit_idx), 0);

    issue(OP_START, 8'd1, 1'b1, 4, 2, 1'b0, "start_after_rst");
    issue(OP_STOP,  8'd1, 1'b1, 6, 0, 1'b0, "stop_after_rst");
    repeat (5) @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
